// File: rtl/forwarding_hazard_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | forwarding_hazard_unit_if : ID decode fields in, hazard controls out     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_BITS = 5,
    parameter int CNT_BITS      = 16
);
    logic [REG_ADDR_BITS-1:0] ID_Rs_i;
    logic [REG_ADDR_BITS-1:0] ID_Rt_i;
    logic                     ID_UsesRs_i;
    logic                     ID_UsesRt_i;
    logic [REG_ADDR_BITS-1:0] ID_Rd_i;
    logic                     ID_RegWrite_i;
    logic                     ID_MemRead_i;
    logic                     Flush_i;
    logic                     Stall_o;
    logic [1:0]               Forward_A_o;
    logic [1:0]               Forward_B_o;
    logic [CNT_BITS-1:0]      Stall_Count_o;

    modport master (
        output ID_Rs_i, ID_Rt_i, ID_UsesRs_i, ID_UsesRt_i,
               ID_Rd_i, ID_RegWrite_i, ID_MemRead_i, Flush_i,
        input  Stall_o, Forward_A_o, Forward_B_o, Stall_Count_o
    );

    modport slave (
        input  ID_Rs_i, ID_Rt_i, ID_UsesRs_i, ID_UsesRt_i,
               ID_Rd_i, ID_RegWrite_i, ID_MemRead_i, Flush_i,
        output Stall_o, Forward_A_o, Forward_B_o, Stall_Count_o
    );
endinterface
`default_nettype wire

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | forwarding_hazard_unit : ALU operand forwarding and load-use stall ctrl  |
// | FORWARDING_EN defined enables bypassing; otherwise stall-only interlock. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module forwarding_hazard_unit #(
    parameter int REG_ADDR_BITS = 5,
    parameter int CNT_BITS      = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    forwarding_hazard_unit_if.slave hz
);
    localparam logic [1:0] c_sel_rf  = 2'b00;
    localparam logic [1:0] c_sel_wb  = 2'b01;
    localparam logic [1:0] c_sel_mem = 2'b10;

    logic [REG_ADDR_BITS-1:0] r_ex_rs;
    logic [REG_ADDR_BITS-1:0] r_ex_rt;
    logic                     r_ex_uses_rs;
    logic                     r_ex_uses_rt;
    logic [REG_ADDR_BITS-1:0] r_ex_rd;
    logic                     r_ex_reg_write;
    logic                     r_ex_mem_read;
    logic [REG_ADDR_BITS-1:0] r_mem_rd;
    logic                     r_mem_reg_write;
    logic [REG_ADDR_BITS-1:0] r_wb_rd;
    logic                     r_wb_reg_write;
    logic [CNT_BITS-1:0]      r_stall_count;

    logic       w_mem_wr_valid;
    logic       w_wb_wr_valid;
    logic       w_ex_wr_valid;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_id_hits_ex;
    logic       w_id_hits_mem;
    logic       w_stall;

    // Register 0 is hardwired, so a write to it is never a real producer.
    assign w_ex_wr_valid  = r_ex_reg_write  && (r_ex_rd  != '0);
    assign w_mem_wr_valid = r_mem_reg_write && (r_mem_rd != '0);
    assign w_wb_wr_valid  = r_wb_reg_write  && (r_wb_rd  != '0);

    always_comb begin
        w_fwd_a = c_sel_rf;
        if (r_ex_uses_rs && w_mem_wr_valid && (r_mem_rd == r_ex_rs))
            w_fwd_a = c_sel_mem;
        else if (r_ex_uses_rs && w_wb_wr_valid && (r_wb_rd == r_ex_rs))
            w_fwd_a = c_sel_wb;
    end

    always_comb begin
        w_fwd_b = c_sel_rf;
        if (r_ex_uses_rt && w_mem_wr_valid && (r_mem_rd == r_ex_rt))
            w_fwd_b = c_sel_mem;
        else if (r_ex_uses_rt && w_wb_wr_valid && (r_wb_rd == r_ex_rt))
            w_fwd_b = c_sel_wb;
    end

    assign w_id_hits_ex  = (hz.ID_UsesRs_i && (hz.ID_Rs_i == r_ex_rd)) ||
                           (hz.ID_UsesRt_i && (hz.ID_Rt_i == r_ex_rd));
    assign w_id_hits_mem = (hz.ID_UsesRs_i && (hz.ID_Rs_i == r_mem_rd)) ||
                           (hz.ID_UsesRt_i && (hz.ID_Rt_i == r_mem_rd));

`ifdef FORWARDING_EN
    assign w_stall        = !hz.Flush_i && r_ex_mem_read && w_ex_wr_valid && w_id_hits_ex;
    assign hz.Forward_A_o = w_fwd_a;
    assign hz.Forward_B_o = w_fwd_b;

    logic w_unused_fwd;
    assign w_unused_fwd = w_id_hits_mem;
`else
    // Without bypassing, a consumer must wait until its producer reaches WB.
    assign w_stall        = !hz.Flush_i &&
                            ((w_ex_wr_valid && w_id_hits_ex) || (w_mem_wr_valid && w_id_hits_mem));
    assign hz.Forward_A_o = c_sel_rf;
    assign hz.Forward_B_o = c_sel_rf;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_fwd_a, w_fwd_b, r_ex_mem_read};
`endif

    assign hz.Stall_o       = w_stall;
    assign hz.Stall_Count_o = r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_ex_uses_rs    <= 1'b0;
            r_ex_uses_rt    <= 1'b0;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
            r_stall_count   <= '0;
        end else begin
            r_wb_rd         <= r_mem_rd;
            r_wb_reg_write  <= r_mem_reg_write;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            if (w_stall || hz.Flush_i) begin
                r_ex_rs        <= '0;
                r_ex_rt        <= '0;
                r_ex_uses_rs   <= 1'b0;
                r_ex_uses_rt   <= 1'b0;
                r_ex_rd        <= '0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end else begin
                r_ex_rs        <= hz.ID_Rs_i;
                r_ex_rt        <= hz.ID_Rt_i;
                r_ex_uses_rs   <= hz.ID_UsesRs_i;
                r_ex_uses_rt   <= hz.ID_UsesRt_i;
                r_ex_rd        <= hz.ID_Rd_i;
                r_ex_reg_write <= hz.ID_RegWrite_i;
                r_ex_mem_read  <= hz.ID_MemRead_i;
            end
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_forwarding_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_forwarding_hazard_unit : directed hazard scenarios with a scoreboard  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_forwarding_hazard_unit;
    localparam int RB = 5;
    localparam int CB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    forwarding_hazard_unit_if #(.REG_ADDR_BITS(RB), .CNT_BITS(CB)) bus ();
    forwarding_hazard_unit_if #(.REG_ADDR_BITS(RB), .CNT_BITS(2))  bus2 ();

    forwarding_hazard_unit #(.REG_ADDR_BITS(RB), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .hz(bus.slave));
    // Narrow-counter copy fed identical stimulus to observe saturation.
    forwarding_hazard_unit #(.REG_ADDR_BITS(RB), .CNT_BITS(2)) dut_sat (
        .clk(clk), .reset(reset), .hz(bus2.slave));

    assign bus2.ID_Rs_i       = bus.ID_Rs_i;
    assign bus2.ID_Rt_i       = bus.ID_Rt_i;
    assign bus2.ID_UsesRs_i   = bus.ID_UsesRs_i;
    assign bus2.ID_UsesRt_i   = bus.ID_UsesRt_i;
    assign bus2.ID_Rd_i       = bus.ID_Rd_i;
    assign bus2.ID_RegWrite_i = bus.ID_RegWrite_i;
    assign bus2.ID_MemRead_i  = bus.ID_MemRead_i;
    assign bus2.Flush_i       = bus.Flush_i;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       ut;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        string      tag;
        logic       st;
        logic [1:0] fa;
        logic [1:0] fb;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   exp_cnt  = 0;

    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        instr_t i;
        i.rs = rs; i.rt = rt; i.ur = 1'b1; i.ut = 1'b1; i.rd = rd; i.rw = 1'b1; i.mr = 1'b0;
        return i;
    endfunction

    function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs);
        instr_t i;
        i.rs = rs; i.rt = 5'd0; i.ur = 1'b1; i.ut = 1'b0; i.rd = rd; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic instr_t addi0();
        instr_t i;
        i = '0;
        i.ur = 1'b1;
        i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".stall"}, {15'd0, bus.Stall_o}, {15'd0, e.st});
        chk({e.tag, ".fwd_a"}, {14'd0, bus.Forward_A_o}, {14'd0, e.fa});
        chk({e.tag, ".fwd_b"}, {14'd0, bus.Forward_B_o}, {14'd0, e.fb});
        chk({e.tag, ".count"}, bus.Stall_Count_o, e.cnt[15:0]);
        chk({e.tag, ".count_sat"}, {14'd0, bus2.Stall_Count_o}, (e.cnt > 3) ? 16'd3 : e.cnt[15:0]);
    endtask

    task automatic drive(input instr_t i, input logic fl);
        bus.ID_Rs_i       = i.rs;
        bus.ID_Rt_i       = i.rt;
        bus.ID_UsesRs_i   = i.ur;
        bus.ID_UsesRt_i   = i.ut;
        bus.ID_Rd_i       = i.rd;
        bus.ID_RegWrite_i = i.rw;
        bus.ID_MemRead_i  = i.mr;
        bus.Flush_i       = fl;
    endtask

    // One ID-stage cycle: present an instruction, then check mid-cycle.
    task automatic step(input string tag, input instr_t i, input logic fl,
                        input logic st, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        @(negedge clk);
        drive(i, fl);
        e.tag = tag; e.st = st; e.fa = fa; e.fb = fb; e.cnt = exp_cnt;
        sb.push_back(e);
        #2;
        check_front();
        if (st) exp_cnt++;
    endtask

    task automatic push_zero(input string tag);
        exp_t e;
        e.tag = tag; e.st = 1'b0; e.fa = 2'b00; e.fb = 2'b00; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    initial begin
        drive(nop(), 1'b0);
        #3;
        push_zero("reset_state");
        check_front();
        @(negedge clk);
        reset = 1'b0;

`ifdef FORWARDING_EN
        step("t1_add",   alu(8, 1, 2),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t1_sub",   alu(9, 8, 10),  1'b0, 1'b0, 2'b00, 2'b00);
        step("t1_ex",    nop(),          1'b0, 1'b0, 2'b10, 2'b00);
        step("t2_add",   alu(8, 1, 2),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_nop",   nop(),          1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_or",    alu(11, 12, 8), 1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_ex",    nop(),          1'b0, 1'b0, 2'b00, 2'b01);
        step("t3_lw",    lw(9, 1),       1'b0, 1'b0, 2'b00, 2'b00);
        step("t3_add",   alu(10, 9, 9),  1'b0, 1'b1, 2'b00, 2'b00);
        step("t3_hold",  alu(10, 9, 9),  1'b0, 1'b0, 2'b00, 2'b00);
        step("t3_ex",    nop(),          1'b0, 1'b0, 2'b01, 2'b01);
        step("t4_addi",  addi0(),        1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_add3",  alu(3, 0, 0),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_ex",    nop(),          1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_p1",    alu(8, 1, 2),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_p2",    alu(8, 3, 4),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_sub",   alu(9, 8, 10),  1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_ex2",   nop(),          1'b0, 1'b0, 2'b10, 2'b00);
`else
        step("t1_add",   alu(8, 1, 2),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t1_sub",   alu(9, 8, 10),  1'b0, 1'b1, 2'b00, 2'b00);
        step("t1_hold1", alu(9, 8, 10),  1'b0, 1'b1, 2'b00, 2'b00);
        step("t1_hold2", alu(9, 8, 10),  1'b0, 1'b0, 2'b00, 2'b00);
        step("t1_ex",    nop(),          1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_add",   alu(8, 1, 2),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_nop",   nop(),          1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_or",    alu(11, 12, 8), 1'b0, 1'b1, 2'b00, 2'b00);
        step("t2_hold",  alu(11, 12, 8), 1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_ex",    nop(),          1'b0, 1'b0, 2'b00, 2'b00);
        step("t3_lw",    lw(9, 1),       1'b0, 1'b0, 2'b00, 2'b00);
        step("t3_add",   alu(10, 9, 9),  1'b0, 1'b1, 2'b00, 2'b00);
        step("t3_hold1", alu(10, 9, 9),  1'b0, 1'b1, 2'b00, 2'b00);
        step("t3_hold2", alu(10, 9, 9),  1'b0, 1'b0, 2'b00, 2'b00);
        step("t3_ex",    nop(),          1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_addi",  addi0(),        1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_add3",  alu(3, 0, 0),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_ex",    nop(),          1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_p1",    alu(8, 1, 2),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_p2",    alu(8, 3, 4),   1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_sub",   alu(9, 8, 10),  1'b0, 1'b1, 2'b00, 2'b00);
        step("t4_hold1", alu(9, 8, 10),  1'b0, 1'b1, 2'b00, 2'b00);
        step("t4_hold2", alu(9, 8, 10),  1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_ex2",   nop(),          1'b0, 1'b0, 2'b00, 2'b00);
`endif
        // Flush beats the stall; the squashed add must not become a producer.
        step("t5_lw",    lw(9, 1),       1'b0, 1'b0, 2'b00, 2'b00);
        step("t5_flush", alu(10, 9, 9),  1'b1, 1'b0, 2'b00, 2'b00);
        step("t5_after", alu(11, 10, 10),1'b0, 1'b0, 2'b00, 2'b00);
        step("t6_lw",    lw(9, 1),       1'b0, 1'b0, 2'b00, 2'b00);
        step("t6_add",   alu(10, 9, 9),  1'b0, 1'b1, 2'b00, 2'b00);

        #1;
        reset = 1'b1;
        exp_cnt = 0;
        #1;
        push_zero("mid_reset");
        check_front();
        @(negedge clk);
        reset = 1'b0;
        #1;

        step("r_add",    alu(10, 9, 9),  1'b0, 1'b0, 2'b00, 2'b00);
        step("r_nop",    nop(),          1'b0, 1'b0, 2'b00, 2'b00);

        for (int k = 0; k < 4; k++) begin
`ifdef FORWARDING_EN
            step("sat_lw",   lw(9, 1),      1'b0, 1'b0, 2'b00, 2'b00);
            step("sat_add",  alu(10, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00);
            step("sat_hold", alu(10, 9, 9), 1'b0, 1'b0, 2'b00, 2'b00);
            step("sat_ex",   nop(),         1'b0, 1'b0, 2'b01, 2'b01);
`else
            step("sat_lw",    lw(9, 1),      1'b0, 1'b0, 2'b00, 2'b00);
            step("sat_add",   alu(10, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00);
            step("sat_hold1", alu(10, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00);
            step("sat_hold2", alu(10, 9, 9), 1'b0, 1'b0, 2'b00, 2'b00);
            step("sat_ex",    nop(),         1'b0, 1'b0, 2'b00, 2'b00);
`endif
        end
        step("final", nop(), 1'b0, 1'b0, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
